// File: rtl/fadd_scheduler.sv
// Round-robin scheduler sharing one pipelined FP adder among several requesters.
// Tags travel beside the adder pipeline so each result returns to its owner.
module fadd_scheduler #(
    parameter int exponent_width = 8,
    parameter int fraction_width = 23,
    parameter int num_req        = 4,
    parameter int add_latency    = 3,
    localparam int W  = exponent_width + fraction_width + 1,
    localparam int IW = $clog2(num_req)
) (
    input  logic                 clk,
    input  logic                 rst_clk,
    input  logic [num_req-1:0]   req_valid,
    input  logic [num_req*W-1:0] req_a,
    input  logic [num_req*W-1:0] req_b,
    output logic [num_req-1:0]   req_ready,
    output logic                 add_valid,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    input  logic [W-1:0]         add_c,
    output logic [num_req-1:0]   rsp_valid,
    output logic [W-1:0]         rsp_c,
    output logic [3:0]           in_flight
);

    logic [IW-1:0]      last_grant;
    logic [IW-1:0]      grant_idx;
    logic               grant_any;
    logic [IW-1:0]      issue_idx;
    logic [add_latency-1:0] tag_valid;
    logic [IW-1:0]      tag_idx [add_latency];
    logic               ret;

    assign ret = tag_valid[add_latency-1];

    // Round-robin pick: first valid requester after the last grant.
    always_comb begin
        int cand;
        cand      = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        for (int off = 1; off <= num_req; off++) begin
            cand = int'(last_grant) + off;
            if (cand >= num_req)
                cand = cand - num_req;
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = IW'(cand);
            end
        end
        if (rst_clk)
            grant_any = 1'b0;
        if (grant_any)
            req_ready[grant_idx] = 1'b1;
    end

    // Register the granted operands toward the adder and advance the pointer.
    always_ff @(posedge clk) begin
        if (rst_clk) begin
            last_grant <= IW'(num_req - 1);
            add_valid  <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            issue_idx  <= '0;
        end else begin
            add_valid <= grant_any;
            if (grant_any) begin
                last_grant <= grant_idx;
                issue_idx  <= grant_idx;
                add_a      <= req_a[grant_idx*W +: W];
                add_b      <= req_b[grant_idx*W +: W];
            end
        end
    end

    // Tag pipeline aligned so its last stage coincides with add_c.
    always_ff @(posedge clk) begin
        if (rst_clk) begin
            tag_valid <= '0;
            for (int i = 0; i < add_latency; i++)
                tag_idx[i] <= '0;
        end else begin
            tag_valid[0] <= add_valid;
            tag_idx[0]   <= issue_idx;
            for (int i = 1; i < add_latency; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_idx[i]   <= tag_idx[i-1];
            end
        end
    end

    // Capture the adder result only when a live tag emerges.
    always_ff @(posedge clk) begin
        if (rst_clk) begin
            rsp_valid <= '0;
            rsp_c     <= '0;
        end else begin
            rsp_valid <= '0;
            if (ret) begin
                rsp_valid[tag_idx[add_latency-1]] <= 1'b1;
                rsp_c <= add_c;
            end
        end
    end

    // Outstanding-operation count from grant to result capture.
    always_ff @(posedge clk) begin
        if (rst_clk) begin
            in_flight <= 4'd0;
        end else begin
            case ({grant_any, ret})
                2'b10:   in_flight <= in_flight + 4'd1;
                2'b01:   in_flight <= in_flight - 4'd1;
                default: in_flight <= in_flight;
            endcase
        end
    end

endmodule

// File: tb/tb_fadd_scheduler.sv
// Directed bench for fadd_scheduler with a 3-stage mock adder.
// Mock adder drives random garbage whenever no result is due.
module tb_fadd_scheduler;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_clk = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic           add_valid;
    logic [W-1:0]   add_a, add_b, add_c;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_c;
    logic [3:0]     in_flight;

    int passed = 0;
    int total  = 0;

    fadd_scheduler dut (
        .clk(clk), .rst_clk(rst_clk),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
        .add_c(add_c),
        .rsp_valid(rsp_valid), .rsp_c(rsp_c), .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000)
            return 32'h40400000;
        return a + b;
    endfunction

    // Mock adder: result appears 3 cycles after add_valid.
    logic pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
    logic [W-1:0] pd0 = '0, pd1 = '0, pd2 = '0;
    logic [W-1:0] garbage = '0;
    always @(posedge clk) begin
        pv0 <= add_valid;
        pd0 <= model(add_a, add_b);
        pv1 <= pv0;
        pd1 <= pd0;
        pv2 <= pv1;
        pd2 <= pd1;
    end
    always @(negedge clk) garbage <= $urandom;
    assign add_c = pv2 ? pd2 : garbage;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic apply_reset();
        rst_clk = 1'b1;
        step();
        rst_clk = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0;
        for (int i = 0; i < 8; i++)
            step();
    endtask

    task automatic test_reset();
        req_valid = '1;
        step();
        step();
        total++;
        if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready);
        else passed++;
        total++;
        if ({add_valid, rsp_valid, in_flight} !== 9'd0)
            $display("FAIL reset_strobes: got %b %b %0d want 0 0000 0", add_valid, rsp_valid, in_flight);
        else passed++;
        total++;
        if ({add_a, add_b, rsp_c} !== 96'd0)
            $display("FAIL reset_data: got %h %h %h want zeros", add_a, add_b, rsp_c);
        else passed++;
        req_valid = '0;
        rst_clk = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [N-1:0] exp_rsp;
        logic [3:0]   exp_if;
        set_op(2, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0100;
        #1;
        total++;
        if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready);
        else passed++;
        step();
        req_valid = '0;
        total++;
        if ({add_valid, add_a, add_b} !== {1'b1, 32'h3F800000, 32'h40000000})
            $display("FAIL single_issue: got %b %h %h want 1 3f800000 40000000", add_valid, add_a, add_b);
        else passed++;
        for (int k = 1; k <= 7; k++) begin
            exp_rsp = (k == 5) ? 4'b0100 : 4'b0000;
            exp_if  = (k < 5) ? 4'd1 : 4'd0;
            total++;
            if (rsp_valid !== exp_rsp || in_flight !== exp_if)
                $display("FAIL single_k%0d: got rsp %b if %0d want %b %0d", k, rsp_valid, in_flight, exp_rsp, exp_if);
            else passed++;
            if (k == 5) begin
                total++;
                if (rsp_c !== 32'h40400000) $display("FAIL single_rsp_c: got %h want 40400000", rsp_c);
                else passed++;
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rsp;
        int g, gr, rt;
        for (int i = 0; i < N; i++)
            set_op(i, 32'h10000000 + i, 32'h00000100 * (i + 1));
        apply_reset();
        for (int c = 0; c <= 13; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                total++;
                if (req_ready !== 4'(1 << (c % 4)))
                    $display("FAIL rr_grant_c%0d: got %b want %b", c, req_ready, 4'(1 << (c % 4)));
                else passed++;
            end
            g = c - 5;
            exp_rsp = (g >= 0 && g < 8) ? 4'(1 << (g % 4)) : 4'b0000;
            total++;
            if (rsp_valid !== exp_rsp)
                $display("FAIL rr_rsp_c%0d: got %b want %b", c, rsp_valid, exp_rsp);
            else passed++;
            if (g >= 0 && g < 8) begin
                total++;
                if (rsp_c !== 32'h10000000 + (g % 4) + 32'h100 * ((g % 4) + 1))
                    $display("FAIL rr_data_c%0d: got %h want %h", c, rsp_c,
                             32'h10000000 + (g % 4) + 32'h100 * ((g % 4) + 1));
                else passed++;
            end
            gr = (c < 8) ? c : 8;
            rt = (c - 4 < 0) ? 0 : ((c - 4 > 8) ? 8 : c - 4);
            total++;
            if (in_flight !== 4'(gr - rt))
                $display("FAIL rr_inflight_c%0d: got %0d want %0d", c, in_flight, gr - rt);
            else passed++;
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        int gr, rt;
        int peak;
        peak = 0;
        set_op(0, 32'h00000005, 32'h00000007);
        for (int c = 0; c <= 15; c++) begin
            req_valid = (c < 10) ? 4'b0001 : 4'b0000;
            gr = (c < 10) ? c : 10;
            rt = (c - 4 < 0) ? 0 : ((c - 4 > 10) ? 10 : c - 4);
            if (int'(in_flight) > peak)
                peak = int'(in_flight);
            total++;
            if (in_flight !== 4'(gr - rt))
                $display("FAIL b2b_inflight_c%0d: got %0d want %0d", c, in_flight, gr - rt);
            else passed++;
            step();
        end
        total++;
        if (peak !== 4) $display("FAIL b2b_peak: got %0d want 4", peak);
        else passed++;
        req_valid = '0;
    endtask

    task automatic test_drop();
        apply_reset();
        req_valid = 4'b1010;
        #1;
        total++;
        if (req_ready !== 4'b0010) $display("FAIL drop_g0: got %b want 0010", req_ready);
        else passed++;
        step();
        #1;
        total++;
        if (req_ready !== 4'b1000) $display("FAIL drop_g1: got %b want 1000", req_ready);
        else passed++;
        step();
        req_valid = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (req_ready !== 4'b0010) $display("FAIL drop_g%0d: got %b want 0010", i + 2, req_ready);
            else passed++;
            step();
        end
        req_valid = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (req_ready !== 4'b0000) $display("FAIL drop_idle%0d: got %b want 0000", i, req_ready);
            else passed++;
            step();
        end
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0100) $display("FAIL drop_resume: got %b want 0100", req_ready);
        else passed++;
        req_valid = '0;
        drain();
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        req_valid = 4'b1111;
        step();
        step();
        step();
        req_valid = 4'b0000;
        total++;
        if (in_flight !== 4'd3) $display("FAIL mid_pre_inflight: got %0d want 3", in_flight);
        else passed++;
        rst_clk = 1'b1;
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b want 0000", req_ready);
        else passed++;
        step();
        rst_clk = 1'b0;
        req_valid = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid !== 4'b0000 || in_flight !== 4'd0)
                bad++;
            step();
        end
        total++;
        if (bad !== 0) $display("FAIL mid_post_reset: got %0d bad cycles want 0", bad);
        else passed++;
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0001) $display("FAIL mid_next_grant: got %b want 0001", req_ready);
        else passed++;
        req_valid = '0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        drain();
        test_back_to_back();
        drain();
        test_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
